freq_meas_ctrl: RTL and testbench

Auto-ranging sequencer for the period-averaging frequency counter datapath. It sets the datapath's averaging length (times_out, always a power of two) and clears the datapath between windows. It collects each window count and steps the range until the count lands inside a target window. It reports each result over a valid/ready handshake and detects an absent input signal with a watchdog.

---
 rtl/freq_meas_pkg.sv | 22 ++
 rtl/freq_meas_watchdog.sv | 47 ++++
 rtl/freq_meas_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_freq_meas_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared types and constants for the frequency-measurement
// sequencer.
//   state_e  : sequencer states (IDLE, ARM, WAIT, EVAL, REPORT)
//   ST_*     : result status codes reported on res_status
//   AVG_N    : samples averaged per result when FREQ_MEAS_CTRL_AVG_EN is defined
package freq_meas_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      WAIT   = 3'd2,
      EVAL   = 3'd3,
      REPORT = 3'd4
   } state_e;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_RANGE   = 2'b10;

   localparam int AVG_N = 4;

endpackage

// File: rtl/freq_meas_watchdog.sv
// freq_meas_watchdog: loadable saturating cycle counter.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : force count to zero (highest priority)
//   load      : load load_val
//   load_val  : value loaded when load=1
//   inc       : count up by one; holds once TIMEOUT-1 is reached
//   expire    : count has reached TIMEOUT-1
module freq_meas_watchdog #(
   parameter int TIMEOUT = 50000000,
   parameter int W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic         expire
);

   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (inc && (cnt_q < LAST)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // >= so that a loaded value beyond the limit still reports expiry.
   assign expire = (cnt_q >= LAST);

endmodule

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: auto-ranging sequencer for the period-averaging frequency
// counter datapath. Sets the averaging length (times_out = 2^k), clears the
// datapath between windows, steps k until the window count lands inside
// [CNT_LO, CNT_HI], and reports results over a valid/ready handshake.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : single-shot request pulse (ignored while busy)
//   continuous            : level, re-arm automatically after each report
//   meas_valid, meas_cnt  : completed window from the datapath
//   times_out             : averaging length to the datapath (2^k)
//   dp_clr                : one-cycle datapath clear pulse
//   res_valid, res_ready  : result handshake
//   res_cnt, res_shift    : result count and the k it was taken at
//   res_status            : ST_OK / ST_TIMEOUT / ST_RANGE
//   busy                  : sequencer not idle
//   dbg_state             : current sequencer state (freq_meas_pkg::state_e)
//
// Result handshake: res_valid rises with the result and stays high with
// res_cnt/res_shift/res_status frozen until a cycle where res_ready=1; that
// cycle is the transfer, and res_valid drops on the following edge.
//
// Optional build macro FREQ_MEAS_CTRL_AVG_EN: in-window counts at a fixed k are
// averaged over AVG_N windows before a single result is reported.
module freq_meas_ctrl #(
   parameter int CW      = 32,
   parameter int KMAX    = 10,
   parameter int CNT_LO  = 65536,
   parameter int CNT_HI  = 16777216,
   parameter int TIMEOUT = 50000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          continuous,
   input  logic          meas_valid,
   input  logic [CW-1:0] meas_cnt,
   output logic [31:0]   times_out,
   output logic          dp_clr,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [CW-1:0] res_cnt,
   output logic [3:0]    res_shift,
   output logic [1:0]    res_status,
   output logic          busy,
   output logic [2:0]    dbg_state
);

   import freq_meas_pkg::*;

   localparam logic [CW-1:0] LO    = CW'(CNT_LO);
   localparam logic [CW-1:0] HI    = CW'(CNT_HI);
   localparam logic [3:0]    K_TOP = 4'(KMAX);

   state_e        state_q, state_d;
   logic [3:0]    k_q, k_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          discard_q, discard_d;
   logic          dp_clr_q, dp_clr_d;
   logic          res_valid_q, res_valid_d;
   logic [CW-1:0] res_cnt_q, res_cnt_d;
   logic [3:0]    res_shift_q, res_shift_d;
   logic [1:0]    res_status_q, res_status_d;
   logic          busy_q, busy_d;
   logic          wd_clr, wd_inc, wd_expire;
   logic          cnt_low, cnt_high;

`ifdef FREQ_MEAS_CTRL_AVG_EN
   localparam int NW = $clog2(AVG_N);
   logic [CW+1:0] acc_q, acc_d, acc_sum;
   logic [NW-1:0] n_q, n_d;
`endif

   freq_meas_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr      (wd_clr),
      .load     (1'b0),
      .load_val ('0),
      .inc      (wd_inc),
      .expire   (wd_expire)
   );

   // An all-ones count means the datapath counter saturated: always too high.
   assign cnt_low  = (cnt_q < LO);
   assign cnt_high = (cnt_q > HI) || (&cnt_q);

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      cnt_d        = cnt_q;
      discard_d    = discard_q;
      res_cnt_d    = res_cnt_q;
      res_shift_d  = res_shift_q;
      res_status_d = res_status_q;
      wd_clr       = 1'b0;
      wd_inc       = 1'b0;
`ifdef FREQ_MEAS_CTRL_AVG_EN
      acc_d        = acc_q;
      n_d          = n_q;
      acc_sum      = acc_q + {2'b00, cnt_q};
`endif
      case (state_q)
         IDLE: begin
            if (start || continuous) begin
               state_d = ARM;
`ifdef FREQ_MEAS_CTRL_AVG_EN
               acc_d = '0;
               n_d   = '0;
`endif
            end
         end
         ARM: begin
            wd_clr    = 1'b1;
            discard_d = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            wd_inc = 1'b1;
            // A valid pulse beats a simultaneous watchdog expiry.
            if (meas_valid) begin
               if (discard_q) begin
                  // First window after a clear straddles it: drop and rewait.
                  discard_d = 1'b0;
                  wd_clr    = 1'b1;
               end else begin
                  cnt_d   = meas_cnt;
                  state_d = EVAL;
               end
            end else if (wd_expire) begin
               res_cnt_d    = '0;
               res_shift_d  = '0;
               res_status_d = ST_TIMEOUT;
               k_d          = '0;
               state_d      = REPORT;
`ifdef FREQ_MEAS_CTRL_AVG_EN
               acc_d = '0;
               n_d   = '0;
`endif
            end
         end
         EVAL: begin
            if (cnt_low && (k_q < K_TOP)) begin
               k_d     = k_q + 4'd1;
               state_d = ARM;
`ifdef FREQ_MEAS_CTRL_AVG_EN
               acc_d = '0;
               n_d   = '0;
`endif
            end else if (cnt_high && (k_q != 4'd0)) begin
               k_d     = k_q - 4'd1;
               state_d = ARM;
`ifdef FREQ_MEAS_CTRL_AVG_EN
               acc_d = '0;
               n_d   = '0;
`endif
            end else if (cnt_low || cnt_high) begin
               // Out of window at a range limit: report as-is.
               res_cnt_d    = cnt_q;
               res_shift_d  = k_q;
               res_status_d = ST_RANGE;
               state_d      = REPORT;
            end else begin
`ifdef FREQ_MEAS_CTRL_AVG_EN
               if (n_q == NW'(AVG_N - 1)) begin
                  res_cnt_d    = acc_sum[CW+1:2];
                  res_shift_d  = k_q;
                  res_status_d = ST_OK;
                  state_d      = REPORT;
                  acc_d        = '0;
                  n_d          = '0;
               end else begin
                  acc_d   = acc_sum;
                  n_d     = n_q + NW'(1);
                  state_d = ARM;
               end
`else
               res_cnt_d    = cnt_q;
               res_shift_d  = k_q;
               res_status_d = ST_OK;
               state_d      = REPORT;
`endif
            end
         end
         REPORT: begin
            if (res_ready) begin
               state_d = continuous ? ARM : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs registered from the next state so they line up with it.
      dp_clr_d    = (state_d == ARM);
      res_valid_d = (state_d == REPORT);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         k_q          <= '0;
         cnt_q        <= '0;
         discard_q    <= 1'b0;
         dp_clr_q     <= 1'b0;
         res_valid_q  <= 1'b0;
         res_cnt_q    <= '0;
         res_shift_q  <= '0;
         res_status_q <= ST_OK;
         busy_q       <= 1'b0;
`ifdef FREQ_MEAS_CTRL_AVG_EN
         acc_q        <= '0;
         n_q          <= '0;
`endif
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         cnt_q        <= cnt_d;
         discard_q    <= discard_d;
         dp_clr_q     <= dp_clr_d;
         res_valid_q  <= res_valid_d;
         res_cnt_q    <= res_cnt_d;
         res_shift_q  <= res_shift_d;
         res_status_q <= res_status_d;
         busy_q       <= busy_d;
`ifdef FREQ_MEAS_CTRL_AVG_EN
         acc_q        <= acc_d;
         n_q          <= n_d;
`endif
      end
   end

   assign times_out  = 32'd1 << k_q;
   assign dp_clr     = dp_clr_q;
   assign res_valid  = res_valid_q;
   assign res_cnt    = res_cnt_q;
   assign res_shift  = res_shift_q;
   assign res_status = res_status_q;
   assign busy       = busy_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: directed + randomized bench for freq_meas_ctrl.
// The reference model tracks only the range index k and applies the
// ranging rules to each non-stale window count.
module tb_freq_meas_ctrl;

   localparam int unsigned CW      = 32;
   localparam int unsigned KMAX    = 4;
   localparam int unsigned CNT_LO  = 100;
   localparam int unsigned CNT_HI  = 400;
   localparam int unsigned TIMEOUT = 1000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          continuous = 1'b0;
   logic          meas_valid = 1'b0;
   logic [CW-1:0] meas_cnt = '0;
   logic [31:0]   times_out;
   logic          dp_clr;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [CW-1:0] res_cnt;
   logic [3:0]    res_shift;
   logic [1:0]    res_status;
   logic          busy;
   logic [2:0]    dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int exp_k = 0;

   freq_meas_ctrl #(
      .CW(CW), .KMAX(KMAX), .CNT_LO(CNT_LO), .CNT_HI(CNT_HI), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .meas_valid(meas_valid), .meas_cnt(meas_cnt), .times_out(times_out),
      .dp_clr(dp_clr), .res_valid(res_valid), .res_ready(res_ready),
      .res_cnt(res_cnt), .res_shift(res_shift), .res_status(res_status),
      .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- clock / time limit ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_time_limit observed=running expected=finished");
      $fatal(1, "time limit");
   end

   // ---------------- driver / check tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_times_out"}, times_out, 1);
      chk({pfx, "_dp_clr"}, dp_clr, 0);
      chk({pfx, "_res_valid"}, res_valid, 0);
      chk({pfx, "_res_cnt"}, res_cnt, 0);
      chk({pfx, "_res_shift"}, res_shift, 0);
      chk({pfx, "_res_status"}, res_status, 0);
      chk({pfx, "_busy"}, busy, 0);
   endtask

   task automatic pulse_valid(input logic [CW-1:0] c);
      meas_valid = 1'b1;
      meas_cnt   = c;
      tick();
      meas_valid = 1'b0;
   endtask

   task automatic begin_meas();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_dp_clr", dp_clr, 1);
      chk("start_busy", busy, 1);
      chk("start_times_out", times_out, 64'd1 << exp_k);
   endtask

   // Called one cycle after dp_clr rose. Feeds a stale window then a real one
   // and checks the outcome the model predicts for that count.
   task automatic window(input logic [CW-1:0] stale, input logic [CW-1:0] c,
                         input bit poke_start, output bit reported);
      bit low, high;
      tick();
      if (poke_start) begin
         start = 1'b1;
         tick();
         start = 1'b0;
         chk("wait_start_ignored_clr", dp_clr, 0);
         chk("wait_start_ignored_busy", busy, 1);
      end
      repeat ($urandom_range(0, 3)) tick();
      pulse_valid(stale);
      repeat ($urandom_range(0, 3)) tick();
      pulse_valid(c);
      tick();
      low  = (c < CNT_LO);
      high = (c > CNT_HI);
      reported = 1'b0;
      if (low && exp_k < int'(KMAX)) exp_k++;
      else if (high && exp_k > 0) exp_k--;
      else reported = 1'b1;
      if (!reported) begin
         chk("step_dp_clr", dp_clr, 1);
         chk("step_no_valid", res_valid, 0);
         chk("step_times_out", times_out, 64'd1 << exp_k);
      end else begin
         chk("rep_valid", res_valid, 1);
         chk("rep_cnt", res_cnt, c);
         chk("rep_shift", res_shift, exp_k);
         chk("rep_status", res_status, (low || high) ? 2 : 0);
      end
   endtask

   task automatic accept(input bit cont);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("hs_valid_drop", res_valid, 0);
      if (cont) chk("hs_rearm_dp_clr", dp_clr, 1);
      else      chk("hs_idle_busy", busy, 0);
   endtask

   function automatic logic [CW-1:0] rand_cnt(input int sel);
      if (sel == 0) return CW'($urandom_range(0, CNT_LO - 1));
      if (sel == 1) return CW'($urandom_range(CNT_LO, CNT_HI));
      return CW'($urandom_range(CNT_HI + 1, 32'hFFFF_FFFF));
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      bit rep;
      int elapsed;
      int nwin;
      logic [CW-1:0] c;

      // reset state
      tick();
      tick();
      chk_reset_vals("reset");
      rst = 1'b0;
      tick();
      chk_reset_vals("post_reset");

      // 1: stale 50 discarded, 250 in window at k=0
      begin_meas();
      window(50, 250, 1'b0, rep);
      accept(1'b0);

      // 2: ranging up 0 -> 2
      begin_meas();
      window($urandom, 30, 1'b0, rep);
      window($urandom, 60, 1'b0, rep);
      window($urandom, 120, 1'b0, rep);
      chk("s2_reported", rep, 1);
      accept(1'b0);

      // 3: no signal
      begin_meas();
      elapsed = 0;
      while (!res_valid && elapsed < 1200) begin
         tick();
         elapsed++;
      end
      exp_k = 0;
      chk("to_valid", res_valid, 1);
      chk("to_latency", elapsed, TIMEOUT + 1);
      chk("to_cnt", res_cnt, 0);
      chk("to_status", res_status, 1);
      chk("to_times_out", times_out, 1);
      accept(1'b0);

      // 4a: upper range limit
      begin_meas();
      rep = 1'b0;
      nwin = 0;
      while (!rep && nwin < 10) begin
         window($urandom, rand_cnt(0), 1'b0, rep);
         nwin++;
      end
      chk("lim_hi_shift", res_shift, KMAX);
      accept(1'b0);

      // 4b: walk down to k=0, then all-ones count at the lower limit
      begin_meas();
      while (exp_k > 0) window($urandom, rand_cnt(2), 1'b0, rep);
      window($urandom, 32'hFFFF_FFFF, 1'b0, rep);
      chk("lim_lo_status", res_status, 2);
      accept(1'b0);

      // randomized measurements
      for (int m = 0; m < 8; m++) begin
         begin_meas();
         rep = 1'b0;
         nwin = 0;
         while (!rep) begin
            c = (nwin >= 11) ? rand_cnt(1) : rand_cnt($urandom_range(0, 2));
            window($urandom, c, 1'b0, rep);
            nwin++;
         end
         accept(1'b0);
      end

      // 5: continuous, back-pressure, start ignored during WAIT
      continuous = 1'b1;
      tick();
      chk("cont_dp_clr", dp_clr, 1);
      chk("cont_times_out", times_out, 64'd1 << exp_k);
      c = rand_cnt(1);
      window($urandom, c, 1'b1, rep);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_valid", res_valid, 1);
         chk("hold_cnt", res_cnt, c);
         chk("hold_shift", res_shift, exp_k);
         chk("hold_status", res_status, 0);
         chk("hold_no_clr", dp_clr, 0);
      end
      accept(1'b1);
      continuous = 1'b0;
      window($urandom, rand_cnt(1), 1'b0, rep);
      accept(1'b0);

      // 6a: reset mid-WAIT after a range step
      begin_meas();
      window($urandom, (exp_k < int'(KMAX)) ? rand_cnt(0) : rand_cnt(2), 1'b0, rep);
      tick();
      tick();
      #3 rst = 1'b1;
      #1 chk_reset_vals("rst_wait");
      exp_k = 0;
      #2 rst = 1'b0;
      tick();

      // 6b: reset while a result is pending
      begin_meas();
      window($urandom, 200, 1'b0, rep);
      #3 rst = 1'b1;
      #1 chk_reset_vals("rst_report");
      #2 rst = 1'b0;
      tick();
      begin_meas();
      window($urandom, 150, 1'b0, rep);
      accept(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
